// File: rtl/sample_accumulator.sv
// sample_accumulator
//   Sums blocks of 2**CNT_W unsigned samples and presents the block sum and
//   its truncated mean. It holds the result until downstream takes it.
//
//   Ports
//     clk        single clock; all state updates on its rising edge
//     rst        synchronous reset, active low
//     start      one-cycle request to begin a block (honoured only in IDLE)
//     in_data    unsigned sample, DATA_W bits
//     in_valid   in_data is valid this cycle
//     in_ready   block accepts in_data this cycle (state-only)
//     sum        accumulated block sum, SUM_W bits
//     avg        block mean, sum >> CNT_W (truncated)
//     out_valid  sum/avg hold a completed result (state-only)
//     out_ready  downstream consumes the result (only meaningful in DONE)
//     busy       high in any state other than IDLE
module sample_accumulator #(
  parameter  int DATA_W = 15,
  parameter  int CNT_W  = 4,
  localparam int SUM_W  = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] avg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  state_t             state_q;
  state_t             state_d;
  logic [SUM_W-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               clr;
  logic               accept;

  // Truncating mean: dropping CNT_W LSBs divides by the block length.
  function automatic logic [DATA_W-1:0] mean_trunc(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:CNT_W];
  endfunction

  // Next-state and handshake decode; outputs come from state alone.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          clr     = 1'b1;
        end
      end
      ACC: begin
        if (in_valid) begin
          accept = 1'b1;
          if (cnt_q == CNT_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, running sum and sample count. The sum is SUM_W wide, so a full
  // block of maximum samples fits without overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        sum_q <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        sum_q <= sum_q + {{CNT_W{1'b0}}, in_data};
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign avg       = mean_trunc(sum_q);

endmodule

// File: tb/tb_sample_accumulator.sv
module tb_sample_accumulator;
  localparam int DATA_W = 15;
  localparam int CNT_W  = 4;
  localparam int SUM_W  = DATA_W + CNT_W;
  localparam int BLK    = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] avg;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;

  sample_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .avg(avg),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: phase 0 = waiting for start, 1 = collecting, 2 = result held.
  // m_sum is the arithmetic total of samples taken in the current block.
  int     m_phase = 0;
  longint m_sum   = 0;
  int     m_n     = 0;

  int cyc  = 0;
  int t_ov = -1;
  always @(posedge clk) cyc++;
  always @(posedge out_valid) t_ov = cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic st, input logic iv, input logic [DATA_W-1:0] d,
                      input logic ordy, input logic rs);
    start = st; in_valid = iv; in_data = d; out_ready = ordy; rst = rs;
    if (!rs) begin
      m_phase = 0; m_sum = 0; m_n = 0;
    end else if (m_phase == 0) begin
      if (st) begin m_phase = 1; m_sum = 0; m_n = 0; end
    end else if (m_phase == 1) begin
      if (iv) begin
        m_sum += longint'(d);
        m_n++;
        if (m_n == BLK) begin m_phase = 2; m_n = 0; end
      end
    end else begin
      if (ordy) m_phase = 0;
    end
    @(posedge clk); #1;
    check("in_ready",  in_ready,  (m_phase == 1));
    check("out_valid", out_valid, (m_phase == 2));
    check("busy",      busy,      (m_phase != 0));
    check("sum",       sum,       m_sum);
    check("avg",       avg,       m_sum / BLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    int t0;
    logic [SUM_W-1:0] held;
    logic [DATA_W-1:0] rd;
    bit done_ok;

    // Reset, with start/valid/ready all asserted to show reset wins.
    step(1'b1, 1'b1, 15'd5, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    idle(5);
    check("rst_sum0", sum, 0);
    check("rst_avg0", avg, 0);
    check("rst_outv0", out_valid, 0);

    // in_valid in IDLE must not accumulate.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 15'd100, 1'b0, 1'b1);

    // Samples 1..16 back-to-back; latency measured from start.
    t0 = cyc;
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= BLK; i++) step(1'b0, 1'b1, DATA_W'(i), 1'b0, 1'b1);
    check("seq_sum136", sum, 136);
    check("seq_avg8", avg, 8);
    check("seq_latency17", t_ov - t0, 17);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("seq_idle_after_ack", out_valid, 0);
    check("seq_sum_kept", sum, 136);

    // Full-scale samples with in_valid toggling.
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * BLK; i++) step(1'b0, (i % 2 == 0), 15'h7FFF, 1'b0, 1'b1);
    check("max_sum", sum, 524272);
    check("max_avg", avg, 32767);

    // Hold DONE with out_ready=0, pulse start and in_valid meanwhile.
    held = sum;
    for (int i = 0; i < 10; i++) step((i % 3 == 0), 1'b1, 15'd9, 1'b0, 1'b1);
    check("hold_sum", sum, held);
    check("hold_outv", out_valid, 1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("hold_release", out_valid, 0);

    // Abort a block after 7 samples, then a clean block of 2s.
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 15'd1000, 1'b0, 1'b1);
    step(1'b0, 1'b1, 15'd1000, 1'b0, 1'b0);
    check("abort_sum0", sum, 0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < BLK; i++) step(1'b0, 1'b1, 15'd2, 1'b0, 1'b1);
    check("abort_sum32", sum, 32);
    check("abort_avg2", avg, 2);

    // Reset while a result is pending discards it.
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("rst_done_outv", out_valid, 0);
    check("rst_done_sum", sum, 0);

    // Randomised blocks: random gaps, data, stray start/out_ready in ACC.
    for (int b = 0; b < 4; b++) begin
      step(1'b1, 1'b0, '0, 1'b0, 1'b1);
      done_ok = 1'b0;
      for (int k = 0; k < 300 && !done_ok; k++) begin
        rd = DATA_W'($urandom);
        step(1'($urandom_range(0, 1) == 0 && k % 5 == 0), 1'($urandom_range(0, 1)),
             rd, 1'($urandom_range(0, 1)), 1'b1);
        done_ok = (m_phase == 2);
      end
      check("rand_block_done", out_valid, 1);
      for (int w = 0; w < int'($urandom_range(0, 5)); w++)
        step(1'b1, 1'b1, DATA_W'($urandom), 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1, 1'b1);
      idle(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sample_accumulator.md
SAMPLE_ACCUMULATOR -- requirements
Module: sample_accumulator

Interface
REQ-001 Parameter DATA_W, default 15: width of each unsigned input sample.
REQ-002 Parameter CNT_W, default 4: log2 of samples per block (block length 2**CNT_W = 16).
REQ-003 Derived width SUM_W = DATA_W+CNT_W (19 at defaults); the sum SHALL never overflow.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-006 start  input  1  one-cycle request to begin a new block.
REQ-007 in_data  input  DATA_W  unsigned sample.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 sum  output  SUM_W  accumulated block sum.
REQ-011 avg  output  DATA_W  block mean, sum >> CNT_W (truncated).
REQ-012 out_valid  output  1  sum/avg hold a completed result.
REQ-013 out_ready  input  1  downstream consumes the result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACC and DONE, encoded in registers updated on posedge clk.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 -> ACC next cycle, with sum and count cleared to 0 on that edge.
REQ-017 start SHALL be ignored in ACC and DONE.
REQ-018 ACC: in_ready=1; a sample is accepted on an edge where in_valid=1 and in_ready=1.
REQ-019 On acceptance: sum <= sum + zero-extended in_data; count <= count+1 (CNT_W bits, wraps to 0).
REQ-020 in_valid=0 in ACC: sum and count hold; no timeout.
REQ-021 Acceptance with count = 2**CNT_W-1 SHALL be the last sample of the block: state -> DONE, count wraps to 0.
REQ-022 DONE: out_valid=1, in_ready=0; sum and avg SHALL remain stable until handshake.
REQ-023 DONE with out_ready=1 -> IDLE next edge; out_valid low from that cycle on.
REQ-024 sum SHALL keep its last value in IDLE until the next start clears it.
REQ-025 avg SHALL be combinational from the sum register: sum[SUM_W-1:CNT_W].
REQ-026 Latency: out_valid rises on the edge that accepts the 16th sample; minimum start-to-out_valid is 17 cycles.
REQ-027 in_ready and out_valid SHALL depend only on state, with no combinational path from inputs.
REQ-028 out_ready outside DONE SHALL have no effect.

Reset
REQ-029 rst=0 at posedge clk: state=IDLE, sum=0, count=0, so in_ready=0, out_valid=0, busy=0, avg=0.
REQ-030 Reset SHALL override start, in_valid and out_ready in the same cycle.
REQ-031 Reset mid-block (ACC or DONE) SHALL discard the partial or pending result; no output is produced for that block.
REQ-032 Between reset and the first start, out_valid=0 and outputs are unknown-free (all 0).

Verification
REQ-033 Reset then idle 5 cycles -> sum=0, avg=0, in_ready=0, out_valid=0, busy=0.
REQ-034 start, 16 back-to-back samples of value 1..16 -> out_valid on the 16th acceptance edge, sum=136, avg=8.
REQ-035 start, 16 samples of 32767 with in_valid toggling 1/0 -> sum=524272 (0x7FFF0), avg=32767, no overflow.
REQ-036 out_ready held 0 for 10 cycles in DONE, start pulsed meanwhile -> out_valid and sum stable, start ignored; out_ready=1 -> IDLE next cycle.
REQ-037 rst=0 after 7 accepted samples, then start and 16 samples of 2 -> sum=32, avg=2, with no contamination from the aborted block.
REQ-038 in_valid=1 in IDLE and DONE -> no acceptance, sum and count unchanged.
